// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, PC step and the prefetch FIFO entry layout.
package ifetch_pkg;

  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, with a flush that
// empties it in one edge. Push is ignored when full unless a pop frees a slot.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [ENTRY_W-1:0]       i_data,
  output logic [ENTRY_W-1:0]       o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Flush has priority over a same-cycle push so nothing stale survives.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and
// feeds decode through the prefetch FIFO; handles redirect, halt and faults.
//
// Handshake: decode takes the head on a rising edge where inst_valid and
// inst_ready are both high; inst_valid never depends on inst_ready, and the
// head (inst_pc/inst_data) stays put until it is taken or flushed.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_WORDS  = 1000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [31:0]                  rom_addr,
  input  logic [31:0]                  rom_data,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [31:0]                  inst_data,
  output logic [31:0]                  inst_pc,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt_req,
  output logic                         fault,
  output logic [31:0]                  fault_pc,
  output logic [1:0]                   o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]  o_dbg_count
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [31:0]                 r_fetch_pc;
  logic [31:0]                 w_fetch_pc_nxt;
  logic [31:0]                 r_fault_pc;
  logic [31:0]                 w_fault_pc_nxt;
  logic                        w_fetch;
  logic                        w_pop;
  logic                        w_in_range;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  fetch_entry_t                w_push_entry;
  fetch_entry_t                w_head;

  assign rom_addr     = {2'b00, r_fetch_pc[31:2]};
  assign w_in_range   = (rom_addr < ROM_LIMIT);
  assign inst_valid   = !w_empty;
  assign w_pop        = inst_valid && inst_ready;
  assign w_push_entry = '{pc: r_fetch_pc, inst: rom_data};
  assign inst_pc      = w_head.pc;
  assign inst_data    = w_head.inst;
  assign fault        = (r_state == ST_FAULT);
  assign fault_pc     = r_fault_pc;
  assign o_dbg_state  = r_state;
  assign o_dbg_count  = w_count;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_fault_pc_nxt = r_fault_pc;
    w_fetch        = 1'b0;
    if (redirect) begin
      // Redirect wins over everything; the FIFO is flushed alongside.
      w_fetch_pc_nxt = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        w_state_nxt    = ST_FAULT;
        w_fault_pc_nxt = redirect_pc;
      end else begin
        w_state_nxt = halt_req ? ST_HALT : ST_RUN;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt_req) begin
            w_state_nxt = ST_HALT;
          end else if (!w_in_range) begin
            w_state_nxt    = ST_FAULT;
            w_fault_pc_nxt = r_fetch_pc;
          end else if (!w_full || w_pop) begin
            w_fetch        = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + PC_INC;
          end
        end
        ST_HALT: begin
          if (!halt_req) w_state_nxt = ST_RUN;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a full-size instance and a 3-word-ROM instance share
// the stimulus; a scoreboard checks the (pc, inst) stream of the watched one.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;

  logic [31:0] rom_addr_a, rom_data_a, inst_data_a, inst_pc_a, fault_pc_a;
  logic        inst_valid_a, fault_a;
  logic [1:0]  state_a;
  logic [1:0]  count_a;
  logic [31:0] rom_addr_b, rom_data_b, inst_data_b, inst_pc_b, fault_pc_b;
  logic        inst_valid_b, fault_b;
  logic [1:0]  state_b;
  logic [1:0]  count_b;

  logic [31:0] s_rom_addr, s_inst_data, s_inst_pc, s_fault_pc;
  logic        s_valid, s_fault;
  logic [1:0]  s_state, s_count;

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic        mon_sel = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h8C01_0000;
      32'd1:   return 32'hACC1_0001;
      32'd2:   return 32'h8C02_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign rom_data_a = rom_f(rom_addr_a);
  assign rom_data_b = rom_f(rom_addr_b);

  ifetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(1000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready), .inst_data(inst_data_a),
    .inst_pc(inst_pc_a), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .fault(fault_a), .fault_pc(fault_pc_a),
    .o_dbg_state(state_a), .o_dbg_count(count_a)
  );

  ifetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(3), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .reset(reset), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready), .inst_data(inst_data_b),
    .inst_pc(inst_pc_b), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .fault(fault_b), .fault_pc(fault_pc_b),
    .o_dbg_state(state_b), .o_dbg_count(count_b)
  );

  assign s_rom_addr  = mon_sel ? rom_addr_b   : rom_addr_a;
  assign s_inst_data = mon_sel ? inst_data_b  : inst_data_a;
  assign s_inst_pc   = mon_sel ? inst_pc_b    : inst_pc_a;
  assign s_fault_pc  = mon_sel ? fault_pc_b   : fault_pc_a;
  assign s_valid     = mon_sel ? inst_valid_b : inst_valid_a;
  assign s_fault     = mon_sel ? fault_b      : fault_a;
  assign s_state     = mon_sel ? state_b      : state_a;
  assign s_count     = mon_sel ? count_b      : count_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (mon_en && s_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {s_inst_pc, s_inst_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("stream", {s_inst_pc, s_inst_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, rom_f({2'b00, pc[31:2]})});
  endtask

  task automatic do_reset(input logic rdy);
    mon_en      = 1'b0;
    reset       = 1'b1;
    inst_ready  = rdy;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt_req    = 1'b0;
    tick();
    tick();
    check("rst_valid",    64'(s_valid),    64'd0);
    check("rst_fault",    64'(s_fault),    64'd0);
    check("rst_fault_pc", 64'(s_fault_pc), 64'd0);
    check("rst_rom_addr", 64'(s_rom_addr), 64'd0);
    check("rst_state",    64'(s_state),    64'd0);
    check("rst_count",    64'(s_count),    64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_fault(input string tag);
    int budget = 20;
    while (!s_fault && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 64'(s_fault), 64'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    // Stream from reset with decode always ready.
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) push_exp(32'(4 * i));
    check("first_valid_early", 64'(s_valid), 64'd0);
    tick();
    check("first_valid", 64'(s_valid), 64'd1);
    check("first_pc",    64'(s_inst_pc), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_gapless", 64'(s_valid), 64'd1);
    end
    inst_ready = 1'b0;
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: FIFO fills to two and the head holds.
    do_reset(1'b0);
    repeat (5) tick();
    check("bp_count",    64'(s_count),     64'd2);
    check("bp_head_pc",  64'(s_inst_pc),   64'd0);
    check("bp_head_dat", 64'(s_inst_data), 64'h8C01_0000);
    check("bp_rom_addr", 64'(s_rom_addr),  64'd2);
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_release_valid", 64'(s_valid), 64'd1);
      tick();
    end
    inst_ready = 1'b0;
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_full_again", 64'(s_count), 64'd2);

    // Redirect to 8 while full: one empty cycle, then 8 and 12.
    do_redirect(32'd8);
    check("rd_bubble_valid", 64'(s_valid), 64'd0);
    check("rd_bubble_count", 64'(s_count), 64'd0);
    push_exp(32'd8); push_exp(32'd12);
    tick();
    check("rd_first_valid", 64'(s_valid),     64'd1);
    check("rd_first_pc",    64'(s_inst_pc),   64'd8);
    check("rd_first_data",  64'(s_inst_data), 64'h8C02_0001);
    inst_ready = 1'b1;
    tick();
    check("rd_second_pc", 64'(s_inst_pc), 64'd12);
    tick();
    inst_ready = 1'b0;
    check("rd_drained", 64'(exp_q.size()), 64'd0);

    // Halt for 3 cycles: FIFO drains, no new fetch, resume at next pc.
    tick();
    push_exp(32'd16); push_exp(32'd20);
    halt_req   = 1'b1;
    inst_ready = 1'b1;
    repeat (3) tick();
    check("halt_state",    64'(s_state),    64'd1);
    check("halt_empty",    64'(s_valid),    64'd0);
    check("halt_rom_addr", 64'(s_rom_addr), 64'd6);
    check("halt_drained",  64'(exp_q.size()), 64'd0);
    halt_req   = 1'b0;
    inst_ready = 1'b0;
    tick();
    check("resume_wait", 64'(s_valid), 64'd0);
    tick();
    check("resume_valid", 64'(s_valid),   64'd1);
    check("resume_pc",    64'(s_inst_pc), 64'd24);

    // Three-word ROM: 0, 4, 8 then fault at 12; redirect to 0 recovers.
    mon_en  = 1'b0;
    mon_sel = 1'b1;
    do_reset(1'b1);
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
    wait_fault("oor_fault");
    check("oor_fault_pc", 64'(s_fault_pc), 64'd12);
    check("oor_state",    64'(s_state),    64'd2);
    tick();
    check("oor_drained", 64'(exp_q.size()), 64'd0);
    check("oor_empty",   64'(s_valid),      64'd0);
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8);
    do_redirect(32'd0);
    check("oor_clear_fault", 64'(s_fault), 64'd0);
    check("oor_clear_valid", 64'(s_valid), 64'd0);
    wait_fault("oor_refault");
    check("oor_refault_pc", 64'(s_fault_pc), 64'd12);
    tick();
    check("oor_redrained", 64'(exp_q.size()), 64'd0);

    // Misaligned redirect faults; reset clears it and restarts.
    mon_en     = 1'b0;
    mon_sel    = 1'b0;
    inst_ready = 1'b0;
    do_redirect(32'h6);
    mon_en = 1'b1;
    check("mis_fault",    64'(s_fault),    64'd1);
    check("mis_fault_pc", 64'(s_fault_pc), 64'h6);
    check("mis_valid",    64'(s_valid),    64'd0);
    repeat (3) tick();
    check("mis_hold", 64'(s_fault), 64'd1);
    do_reset(1'b0);
    tick();
    check("mis_restart_pc",   64'(s_inst_pc),   64'd0);
    check("mis_restart_data", 64'(s_inst_data), 64'h8C01_0000);

    // Random decode stalls: order must survive arbitrary backpressure.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) push_exp(32'(4 * i));
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      inst_ready = 1'($urandom_range(0, 1));
      tick();
    end
    inst_ready = 1'b0;
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the MIPS core. It owns the program counter and drives the word address of the combinational instruction ROM. Fetched words are buffered with their PC in a small prefetch FIFO and handed to decode over a valid/ready handshake. It also handles branch/jump redirects, halt requests and fetch faults, and sits between the instruction ROM and the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.
- ROM_WORDS, 1000, number of valid ROM words; word index >= ROM_WORDS is out of range.
- FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, synchronous active-high reset.
- rom_addr, out, 32, ROM word index = {2'b00, fetch_pc[31:2]}; combinational from fetch_pc.
- rom_data, in, 32, ROM word at rom_addr, valid in the same cycle.
- inst_valid, out, 1, FIFO head holds an instruction.
- inst_ready, in, 1, decode accepts the head this cycle.
- inst_data, out, 32, head instruction word.
- inst_pc, out, 32, byte PC of the head instruction.
- redirect, in, 1, one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc, in, 32, new byte PC.
- halt_req, in, 1, level: suspend fetching while high.
- fault, out, 1, controller is in FAULT.
- fault_pc, out, 32, offending byte PC, valid while fault=1.

## Operation

- States: RUN, HALT, FAULT. Reset value is RUN. Reset also sets fetch_pc=RESET_PC, FIFO empty, inst_valid=0, fault=0, fault_pc=0.
- Pop: inst_valid & inst_ready removes the head.
- Fetch (RUN only): occurs when halt_req=0, the word index is < ROM_WORDS, and (count < FIFO_DEPTH or pop this cycle).
  - The fetch pushes {fetch_pc, rom_data} and sets fetch_pc += 4, wrapping modulo 2^32.
- Out-of-range: in RUN with halt_req=0, if the word index is >= ROM_WORDS, enter FAULT with fault_pc=fetch_pc.
  - Nothing is pushed. Entries already in the FIFO still drain normally.
- HALT: entered from RUN when halt_req=1. No fetches occur; the FIFO drains. When halt_req=0, return to RUN in the next cycle.
- Redirect (any state), which has highest priority:
  - Flush the FIFO; a pop in the same cycle still counts as accepted by decode.
  - Load fetch_pc=redirect_pc. No fetch occurs in the redirect cycle.
  - If redirect_pc[1:0] != 0: go to FAULT with fault_pc=redirect_pc.
  - Otherwise: go to HALT if halt_req=1, else RUN.
- FAULT is left only by reset or an aligned redirect. The fault output clears in the same edge that leaves FAULT.
- Simultaneous push and pop leaves count unchanged. Push into a full FIFO is impossible by the fetch rule.

## Timing

- First inst_valid appears 1 cycle after reset deasserts. inst_pc=RESET_PC and inst_data=ROM[RESET_PC>>2] at that point.
- Fetch-to-valid latency is 1 cycle. Sustained throughput is 1 instruction/cycle with inst_ready held high.
- After a redirect edge, inst_valid=0 for exactly 1 cycle. The first valid instruction is the redirect_pc word on the following cycle.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
- halt_req taking effect: a fetch in the cycle halt_req rises is suppressed. Fetching resumes 1 cycle after it falls.
- Reset mid-operation discards the FIFO and all state on that edge.

## Structure

- Shared package `ifetch_pkg`:
  - state encoding (ST_RUN, ST_HALT, ST_FAULT);
  - INST_W=32, the PC increment constant 4;
  - the FIFO entry struct {pc, inst}.
- Natural sub-module: `ifetch_fifo`, a synchronous FIFO with flush, push/pop, count, and full/empty flags.
- The controller FSM and the PC register live in ifetch_ctrl.

## Test plan

- Bench ROM image: word0=0x8C010000, word1=0xACC10001, word2=0x8C020001, all other words 0.
- Reset then stream, inst_ready=1 → (pc,data) = (0,0x8C010000), (4,0xACC10001), (8,0x8C020001) on consecutive cycles. First valid 1 cycle after reset falls.
- Backpressure: inst_ready=0 for 5 cycles → FIFO fills to 2 and the head stays at pc 0. Releasing ready delivers 0, 4, 8 in order with no gaps or duplicates.
- Redirect to 8 while the FIFO is full → exactly 1 cycle with inst_valid=0, then pc 8 (0x8C020001), then pc 12 (0).
- halt_req high 3 cycles → FIFO drains and no new pc appears. Fetching resumes at the next sequential pc 1 cycle after release.
- ROM_WORDS=3 → pcs 0, 4, 8 are delivered, then fault=1 with fault_pc=12. A redirect to 0 clears fault and pc 0 is delivered again.
- Redirect to 0x6 → fault=1 and fault_pc=0x6. A reset pulse returns fault=0 and restarts at RESET_PC.
